// File: rtl/jitt_cfg_pkg.sv
// rtl/jitt_cfg_pkg.sv - shared types and constants for the jitter attenuator config sequencer
package jitt_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ASSERT,
    S_RST_WAIT,
    S_FETCH,
    S_ISSUE,
    S_RESP,
    S_LOCK_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;
  localparam logic [1:0] ERR_RDBK = 2'd3;

  localparam logic [15:0] TBL_END   = 16'hFFFF;
  localparam int          LOCK_QUAL = 16;

endpackage

// File: rtl/jitt_cfg_seq_if.sv
// rtl/jitt_cfg_seq_if.sv - I2C master command/response port between sequencer and CLKGEN I2C master
interface jitt_cfg_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [7:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );
endinterface

// File: rtl/jitt_cfg_lock_mon.sv
// rtl/jitt_cfg_lock_mon.sv - DPLL lock synchroniser, consecutive-cycle qualifier and lock timeout counter
module jitt_cfg_lock_mon
  import jitt_cfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1 << 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic lock_i,
  output logic locked_o,
  output logic timeout_o
);

  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int QW = $clog2(LOCK_QUAL + 1);

  logic [1:0]    sync_q;
  logic [QW-1:0] qual_q;
  logic [TW-1:0] tmo_q;

  // Both counters only run while enabled so each lock wait starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      qual_q <= '0;
      tmo_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], lock_i};
      if (!en_i) begin
        qual_q <= '0;
        tmo_q  <= '0;
      end else begin
        if (!sync_q[1]) begin
          qual_q <= '0;
        end else if (qual_q != QW'(LOCK_QUAL)) begin
          qual_q <= qual_q + 1'b1;
        end
        if (tmo_q != TW'(LOCK_TIMEOUT)) begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign locked_o  = en_i && (qual_q == QW'(LOCK_QUAL));
  assign timeout_o = en_i && (tmo_q == TW'(LOCK_TIMEOUT));

endmodule

// File: rtl/jitt_cfg_seq.sv
// rtl/jitt_cfg_seq.sv - power-up/re-config sequencer for the jitter attenuator
// Optional readback verification of every write: define JITT_CFG_READBACK_EN.
module jitt_cfg_seq
  import jitt_cfg_pkg::*;
#(
  parameter int RST_CYCLES    = 1000,
  parameter int POST_RST_WAIT = 5000,
  parameter int TBL_AW        = 9,
  parameter int LOCK_TIMEOUT  = 1 << 20,
  parameter int MAX_RETRY     = 3
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              jitt_resetn,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  jitt_cfg_seq_if.master    i2c,
  input  logic              lock_in,
  output logic [TBL_AW-1:0] entry_cnt
);

  localparam int WMAX = (RST_CYCLES > POST_RST_WAIT) ? RST_CYCLES : POST_RST_WAIT;
  localparam int CW   = (WMAX > 1) ? $clog2(WMAX + 1) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TBL_AW-1:0] LAST_IDX = '1;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [TBL_AW-1:0] entry_q;
  logic [TBL_AW-1:0] entry_inc;
  logic [RW-1:0]     retry_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        err_code_q;
  logic              jitt_resetn_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic              cmd_valid_q;
  logic [15:0]       cmd_addr_q;
  logic [7:0]        cmd_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_nack_q;
  logic              locked;
  logic              timeout;
`ifdef JITT_CFG_READBACK_EN
  logic              cmd_rnw_q;
  logic [7:0]        rsp_rdata_q;
`endif

  assign entry_inc = (entry_q == LAST_IDX) ? entry_q : entry_q + 1'b1;

  jitt_cfg_lock_mon #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_mon (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .en_i      (state_q == S_LOCK_WAIT),
    .lock_i    (lock_in),
    .locked_o  (locked),
    .timeout_o (timeout)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      entry_q       <= '0;
      retry_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
      jitt_resetn_q <= 1'b0;
      tbl_addr_q    <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_nack_q    <= 1'b0;
`ifdef JITT_CFG_READBACK_EN
      cmd_rnw_q     <= 1'b0;
      rsp_rdata_q   <= '0;
`endif
    end else begin
      // Responses are registered so one landing in the handshake cycle is seen in RESP.
      rsp_valid_q <= i2c.rsp_valid;
      rsp_nack_q  <= i2c.rsp_nack;
`ifdef JITT_CFG_READBACK_EN
      rsp_rdata_q <= i2c.rsp_rdata;
`endif
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q       <= S_RST_ASSERT;
            cnt_q         <= '0;
            jitt_resetn_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            entry_q       <= '0;
            retry_q       <= '0;
            tbl_addr_q    <= '0;
          end
        end
        S_RST_ASSERT: begin
          if (int'(cnt_q) + 1 >= RST_CYCLES) begin
            state_q       <= S_RST_WAIT;
            cnt_q         <= '0;
            jitt_resetn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (int'(cnt_q) + 1 >= POST_RST_WAIT) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            tbl_addr_q <= entry_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FETCH: begin
          // First cycle covers the table read latency; second cycle decodes.
          if (cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else if (tbl_data[23:8] == TBL_END || entry_q == LAST_IDX) begin
            if (LOCK_TIMEOUT == 0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_LOCK_WAIT;
            end
          end else begin
            state_q     <= S_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= tbl_data[23:8];
            cmd_wdata_q <= tbl_data[7:0];
`ifdef JITT_CFG_READBACK_EN
            cmd_rnw_q   <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (i2c.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_valid_q) begin
            if (rsp_nack_q) begin
              if (int'(retry_q) < MAX_RETRY) begin
                retry_q     <= retry_q + 1'b1;
                cmd_valid_q <= 1'b1;
                state_q     <= S_ISSUE;
              end else begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= ERR_NACK;
                busy_q     <= 1'b0;
              end
            end
`ifdef JITT_CFG_READBACK_EN
            else if (!cmd_rnw_q) begin
              cmd_rnw_q   <= 1'b1;
              retry_q     <= '0;
              cmd_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end else if (rsp_rdata_q != cmd_wdata_q) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= ERR_RDBK;
              busy_q     <= 1'b0;
            end
`endif
            else begin
              entry_q    <= entry_inc;
              retry_q    <= '0;
              cnt_q      <= '0;
              tbl_addr_q <= entry_inc;
              state_q    <= S_FETCH;
            end
          end
        end
        S_LOCK_WAIT: begin
          if (locked) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (timeout) begin
            state_q    <= S_ERR;
            error_q    <= 1'b1;
            err_code_q <= ERR_LOCK;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign jitt_resetn   = jitt_resetn_q;
  assign tbl_addr      = tbl_addr_q;
  assign entry_cnt     = entry_q;
  assign i2c.cmd_valid = cmd_valid_q;
  assign i2c.cmd_addr  = cmd_addr_q;
  assign i2c.cmd_wdata = cmd_wdata_q;
`ifdef JITT_CFG_READBACK_EN
  assign i2c.cmd_rnw   = cmd_rnw_q;
`else
  assign i2c.cmd_rnw   = 1'b0;
`endif

endmodule

// File: tb/tb_jitt_cfg_seq.sv
// tb/tb_jitt_cfg_seq.sv - randomized self-checking bench for jitt_cfg_seq against a transaction-level model
module tb_jitt_cfg_seq;
  import jitt_cfg_pkg::*;

  localparam int RST_CYCLES    = 20;
  localparam int POST_RST_WAIT = 30;
  localparam int TBL_AW        = 4;
  localparam int LOCK_TIMEOUT  = 1000;
  localparam int MAX_RETRY     = 3;
  localparam int DEPTH         = 1 << TBL_AW;
`ifdef JITT_CFG_READBACK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        nack;
    logic [7:0]  rdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              lock_in = 1'b0;
  logic              busy, done, error, jitt_resetn;
  logic [1:0]        err_code;
  logic [TBL_AW-1:0] tbl_addr, entry_cnt;
  logic [23:0]       tbl_data = '0;
  logic [TBL_AW-1:0] addr_prev = '0;
  logic [23:0]       tbl [DEPTH];

  jitt_cfg_seq_if i2c ();

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   last_rsp_cyc = -1;
  int   lock_mode = 0;
  int   stall_first = 0;
  int   lat_fix = -1;
  bit   first_cmd = 1'b0;
  bit   stable_ok = 1'b1;
  int   hs_cnt = 0;
  txn_t exp_q[$];
  int   ex_code;
  int   ex_cnt;

  always #5 clk = ~clk;

  jitt_cfg_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .POST_RST_WAIT(POST_RST_WAIT),
    .TBL_AW       (TBL_AW),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .jitt_resetn(jitt_resetn),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .i2c        (i2c),
    .lock_in    (lock_in),
    .entry_cnt  (entry_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Table ROM with one cycle of read latency, cycle counter and DPLL lock stimulus.
  always @(negedge clk) begin
    cyc++;
    tbl_data  = tbl[addr_prev];
    addr_prev = tbl_addr;
    case (lock_mode)
      1:       lock_in = (exp_q.size() == 0) && (last_rsp_cyc >= 0) && (cyc - last_rsp_cyc >= 100);
      2:       lock_in = ((cyc / 8) % 2) == 1;
      default: lock_in = 1'b0;
    endcase
  end

  // I2C master model: pops the expected transaction on each handshake and answers from it.
  initial begin : i2c_model
    bit   seen_on;
    bit   pend_on;
    int   stall_left;
    int   lat_left;
    int   lat;
    logic [24:0] seen;
    txn_t cur;
    seen_on = 1'b0;
    pend_on = 1'b0;
    stall_left = 0;
    lat_left = 0;
    i2c.cmd_ready = 1'b0;
    i2c.rsp_valid = 1'b0;
    i2c.rsp_nack  = 1'b0;
    i2c.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      i2c.cmd_ready = 1'b0;
      i2c.rsp_valid = 1'b0;
      if (!rst_n) begin
        seen_on = 1'b0;
        pend_on = 1'b0;
      end else begin
        if (pend_on) begin
          if (lat_left == 0) begin
            i2c.rsp_valid = 1'b1;
            i2c.rsp_nack  = cur.nack;
            i2c.rsp_rdata = cur.rdata;
            last_rsp_cyc  = cyc;
            pend_on = 1'b0;
          end else begin
            lat_left--;
          end
        end
        if (i2c.cmd_valid) begin
          if (!seen_on) begin
            seen_on = 1'b1;
            seen = {i2c.cmd_rnw, i2c.cmd_addr, i2c.cmd_wdata};
            stall_left = first_cmd ? stall_first : int'($urandom_range(0, 3));
            first_cmd = 1'b0;
          end else if ({i2c.cmd_rnw, i2c.cmd_addr, i2c.cmd_wdata} != seen) begin
            stable_ok = 1'b0;
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            i2c.cmd_ready = 1'b1;
            seen_on = 1'b0;
            hs_cnt++;
            if (exp_q.size() == 0) begin
              check_eq("extra_cmd", exp_q.size(), 1);
              cur = '{rnw: 1'b0, addr: '0, wdata: '0, nack: 1'b0, rdata: '0};
            end else begin
              cur = exp_q.pop_front();
              check_eq("cmd", {i2c.cmd_rnw, i2c.cmd_addr, i2c.cmd_wdata}, {cur.rnw, cur.addr, cur.wdata});
            end
            lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 10));
            if (lat == 0) begin
              i2c.rsp_valid = 1'b1;
              i2c.rsp_nack  = cur.nack;
              i2c.rsp_rdata = cur.rdata;
              last_rsp_cyc  = cyc;
            end else begin
              pend_on  = 1'b1;
              lat_left = lat - 1;
            end
          end
        end
      end
    end
  end

  // Builds the table and the expected transaction list and outcome from the sequencing rules.
  task automatic prep_case(input int n_ent, input int nack_ent, input int nack_n,
                           input int bad_ent, input int lmode, input int stall, input int lat);
    int   eff;
    int   nn;
    bit   stopped;
    txn_t t;
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] a;
      do a = 16'($urandom); while (a == 16'hFFFF);
      tbl[i] = {a, 8'($urandom)};
    end
    if (n_ent < DEPTH) tbl[n_ent][23:8] = 16'hFFFF;
    exp_q.delete();
    eff = (n_ent < DEPTH - 1) ? n_ent : DEPTH - 1;
    ex_code = 0;
    ex_cnt  = eff;
    stopped = 1'b0;
    for (int e = 0; e < eff && !stopped; e++) begin
      nn = (e == nack_ent) ? nack_n : 0;
      for (int a = 0; a <= nn && a <= MAX_RETRY; a++) begin
        t.rnw = 1'b0; t.addr = tbl[e][23:8]; t.wdata = tbl[e][7:0];
        t.nack = (a < nn); t.rdata = '0;
        exp_q.push_back(t);
      end
      if (nn > MAX_RETRY) begin
        ex_code = 1; ex_cnt = e; stopped = 1'b1;
      end else if (RDBK) begin
        t.rnw = 1'b1; t.nack = 1'b0;
        t.rdata = tbl[e][7:0] ^ ((e == bad_ent) ? 8'h01 : 8'h00);
        exp_q.push_back(t);
        if (e == bad_ent) begin
          ex_code = 3; ex_cnt = e; stopped = 1'b1;
        end
      end
    end
    if (!stopped && lmode != 1) ex_code = 2;
    lock_mode    = lmode;
    last_rsp_cyc = -1;
    stall_first  = stall;
    lat_fix      = lat;
    first_cmd    = 1'b1;
    stable_ok    = 1'b1;
    hs_cnt       = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input string name, input int n_ent, input int nack_ent, input int nack_n,
                          input int bad_ent, input int lmode, input int stall, input int lat,
                          input bit mid_start);
    int lowcnt;
    int w;
    int delta;
    prep_case(n_ent, nack_ent, nack_n, bad_ent, lmode, stall, lat);
    pulse_start();
    lowcnt = 0;
    while (jitt_resetn == 1'b0 && lowcnt < RST_CYCLES + 50) begin
      lowcnt++;
      @(negedge clk);
    end
    check_eq({name, ".rst_low"}, lowcnt, RST_CYCLES);
    if (mid_start) begin
      w = 0;
      while (hs_cnt == 0 && n_ent > 0 && w < 2000) begin
        w++;
        @(negedge clk);
      end
      pulse_start();
    end
    w = 0;
    while (busy && w < 20000) begin
      w++;
      @(negedge clk);
    end
    delta = cyc - last_rsp_cyc;
    check_eq({name, ".finished"}, busy, 1'b0);
    @(negedge clk);
    check_eq({name, ".done"}, done, (ex_code == 0));
    check_eq({name, ".error"}, error, (ex_code != 0));
    check_eq({name, ".err_code"}, err_code, ex_code);
    check_eq({name, ".entry_cnt"}, entry_cnt, ex_cnt);
    check_eq({name, ".cmds_left"}, exp_q.size(), 0);
    if (stall > 0) check_eq({name, ".stall_stable"}, stable_ok, 1'b1);
    if (ex_code == 2) check_eq({name, ".lock_tmo_window"},
                               (delta >= LOCK_TIMEOUT) && (delta <= LOCK_TIMEOUT + 10), 1'b1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog busy=%0b done=%0b", busy, done);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.jitt_resetn", jitt_resetn, 1'b0);
    check_eq("rst.cmd_valid", i2c.cmd_valid, 1'b0);
    check_eq("rst.status", {busy, done, error, err_code}, 5'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle.jitt_resetn", jitt_resetn, 1'b0);
    check_eq("idle.outputs", {busy, i2c.cmd_valid, i2c.cmd_rnw, tbl_addr, entry_cnt}, '0);

    run_case("basic", 3, -1, 0, -1, 1, 0, 10, 1'b0);
    run_case("stall50", 3, -1, 0, -1, 1, 50, -1, 1'b0);
    run_case("nack_limit", 3, 1, MAX_RETRY + 1, -1, 1, 0, -1, 1'b0);
    run_case("nack_recover", 4, int'($urandom_range(0, 3)), MAX_RETRY, -1, 1, 0, -1, 1'b0);
    run_case("lock_tmo", 2, -1, 0, -1, 0, 0, -1, 1'b0);
    run_case("lock_glitch", 2, -1, 0, -1, 2, 0, -1, 1'b0);

    prep_case(3, -1, 0, -1, 1, 500, -1);
    pulse_start();
    w = 0;
    while (!i2c.cmd_valid && w < 2000) begin
      w++;
      @(negedge clk);
    end
    check_eq("abort.reached_issue", i2c.cmd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort.cmd_valid", i2c.cmd_valid, 1'b0);
    check_eq("abort.jitt_resetn", jitt_resetn, 1'b0);
    check_eq("abort.busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case("replay", 3, -1, 0, -1, 1, 0, -1, 1'b0);

    run_case("readback", 2, -1, 0, 0, 1, 0, -1, 1'b0);
    run_case("wrap", DEPTH, -1, 0, -1, 1, 0, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_case("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, MAX_RETRY)), -1, 1, int'($urandom_range(0, 4)), -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
